// File: rtl/scaled_sprite_mapper.sv
// Purpose : maps the scan position onto a scaled, animated sprite and composites it over the background.
// Latency : 2 vga_clk edges from DrawX/DrawY to red/green/blue/sprite_hit.
// Backpressure: none; free-running pixel stream, one pixel per vga_clk.
//
// Ports:
//   vga_clk, reset              pixel clock, synchronous active-high reset
//   DrawX, DrawY, blank         scan position and active-display flag (blank high = visible)
//   sprite_x, sprite_y,
//   pos_load                    position update strobe; applied at the next frame start
//   mirror_h                    horizontal flip, captured with pos_load (SPRITE_MIRROR_EN only)
//   anim_en                     animation advance enable, evaluated at each frame start
//   rom_address, rom_q          synchronous sprite ROM, one-cycle read latency
//   pal_index, pal_*            palette lookup (pal_* is combinational from pal_index)
//   bg_*                        background colour aligned with DrawX/DrawY
//   red, green, blue,
//   sprite_hit                  registered composited pixel
//
// Optional feature macro: SPRITE_MIRROR_EN (adds mirror_h and horizontal texel flip).
module scaled_sprite_mapper #(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int SCALE_SH = 1,
  parameter int IDX_W    = 2,
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  parameter int ADDR_W   = 10
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              pos_load,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror_h,
`endif
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit
);

  localparam int BOX_W = SPR_W << SCALE_SH;
  localparam int BOX_H = SPR_H << SCALE_SH;
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FR_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  // Position: pending copy written by pos_load, shadow copy used by the datapath.
  logic [9:0]      r_pend_x;
  logic [9:0]      r_pend_y;
  logic            r_pend_vld;
  logic [9:0]      r_shad_x;
  logic [9:0]      r_shad_y;
`ifdef SPRITE_MIRROR_EN
  logic            r_pend_mir;
  logic            r_shad_mir;
`endif

  logic [DIV_W-1:0] r_div_cnt;
  logic [FR_W-1:0]  r_anim_frame;

  // Stage 1: side information delayed to line up with rom_q.
  logic            r_inbox_d;
  logic            r_blank_d;
  logic [3:0]      r_bg_red_d;
  logic [3:0]      r_bg_green_d;
  logic [3:0]      r_bg_blue_d;

  logic            w_frame_start;
  logic [10:0]     w_dx;
  logic [10:0]     w_dy;
  logic            w_inbox;
  logic [10:0]     w_tx_raw;
  logic [10:0]     w_tx;
  logic [10:0]     w_ty;

  assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

  // 11-bit subtraction: a scan position left of / above the sprite borrows into
  // bit 10, which makes the offset larger than any box size and so out-of-box.
  assign w_dx    = {1'b0, DrawX} - {1'b0, r_shad_x};
  assign w_dy    = {1'b0, DrawY} - {1'b0, r_shad_y};
  assign w_inbox = (w_dx < 11'(BOX_W)) && (w_dy < 11'(BOX_H));

  assign w_tx_raw = w_dx >> SCALE_SH;
  assign w_ty     = w_dy >> SCALE_SH;

`ifdef SPRITE_MIRROR_EN
  assign w_tx = r_shad_mir ? (11'(SPR_W - 1) - w_tx_raw) : w_tx_raw;
`else
  assign w_tx = w_tx_raw;
`endif

  assign rom_address = w_inbox
                     ? (ADDR_W'(r_anim_frame) * ADDR_W'(SPR_W * SPR_H)
                        + ADDR_W'(w_ty) * ADDR_W'(SPR_W)
                        + ADDR_W'(w_tx))
                     : '0;

  assign pal_index = rom_q;

  // Position capture. At a frame start the shadow takes the pending value held
  // before the edge; a simultaneous pos_load lands in pending and keeps the flag set.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_pend_vld <= 1'b0;
      r_shad_x   <= '0;
      r_shad_y   <= '0;
`ifdef SPRITE_MIRROR_EN
      r_pend_mir <= 1'b0;
      r_shad_mir <= 1'b0;
`endif
    end else begin
      if (w_frame_start && r_pend_vld) begin
        r_shad_x   <= r_pend_x;
        r_shad_y   <= r_pend_y;
`ifdef SPRITE_MIRROR_EN
        r_shad_mir <= r_pend_mir;
`endif
      end
      if (pos_load) begin
        r_pend_x   <= sprite_x;
        r_pend_y   <= sprite_y;
`ifdef SPRITE_MIRROR_EN
        r_pend_mir <= mirror_h;
`endif
        r_pend_vld <= 1'b1;
      end else if (w_frame_start) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Animation only advances at frame start so a frame never mixes two images.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_anim_frame <= '0;
    end else if (w_frame_start && anim_en) begin
      if (r_div_cnt == DIV_W'(ANIM_DIV - 1)) begin
        r_div_cnt <= '0;
        if (r_anim_frame == FR_W'(FRAMES - 1)) begin
          r_anim_frame <= '0;
        end else begin
          r_anim_frame <= r_anim_frame + 1'b1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_inbox_d    <= 1'b0;
      r_blank_d    <= 1'b0;
      r_bg_red_d   <= '0;
      r_bg_green_d <= '0;
      r_bg_blue_d  <= '0;
    end else begin
      r_inbox_d    <= w_inbox;
      r_blank_d    <= blank;
      r_bg_red_d   <= bg_red;
      r_bg_green_d <= bg_green;
      r_bg_blue_d  <= bg_blue;
    end
  end

  // Stage 2: composite. Palette index 0 is transparent.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      sprite_hit <= 1'b0;
    end else if (!r_blank_d) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      sprite_hit <= 1'b0;
    end else if (r_inbox_d && (rom_q != '0)) begin
      red        <= pal_red;
      green      <= pal_green;
      blue       <= pal_blue;
      sprite_hit <= 1'b1;
    end else begin
      red        <= r_bg_red_d;
      green      <= r_bg_green_d;
      blue       <= r_bg_blue_d;
      sprite_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scaled_sprite_mapper.sv
module tb_scaled_sprite_mapper;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hit;
  } exp_t;

  logic       vga_clk;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [9:0] sprite_x, sprite_y;
  logic       pos_load;
`ifdef SPRITE_MIRROR_EN
  logic       mirror_h;
`endif
  logic       anim_en;
  logic [9:0] rom_address;
  logic [1:0] rom_q;
  logic [1:0] pal_index;
  logic [3:0] pal_red, pal_green, pal_blue;
  logic [3:0] bg_red, bg_green, bg_blue;
  logic [3:0] red, green, blue;
  logic       sprite_hit;

  int checks = 0;
  int errors = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  // Reference state of the sprite mapper, kept from the requirements.
  bit       m_init = 0;
  int       m_pend_x, m_pend_y, m_shad_x, m_shad_y;
  bit       m_flag;
  bit       m_pend_mir, m_shad_mir;
  int       m_div, m_frame;

  scaled_sprite_mapper dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .pos_load    (pos_load),
`ifdef SPRITE_MIRROR_EN
    .mirror_h    (mirror_h),
`endif
    .anim_en     (anim_en),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pal_index   (pal_index),
    .pal_red     (pal_red),
    .pal_green   (pal_green),
    .pal_blue    (pal_blue),
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .sprite_hit  (sprite_hit)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [1:0] rom_fn(input logic [9:0] a);
    return 2'(a + 10'd1);
  endfunction
  function automatic logic [3:0] pal_r(input logic [1:0] i); return {2'b11, i}; endfunction
  function automatic logic [3:0] pal_g(input logic [1:0] i); return {i, 2'b01}; endfunction
  function automatic logic [3:0] pal_b(input logic [1:0] i); return {1'b1, i, 1'b0}; endfunction
  function automatic logic [3:0] bg_r(input logic [9:0] x); return x[3:0]; endfunction
  function automatic logic [3:0] bg_g(input logic [9:0] y); return y[3:0]; endfunction
  function automatic logic [3:0] bg_b(input logic [9:0] x, input logic [9:0] y);
    return x[7:4] ^ y[7:4];
  endfunction

  // Synchronous ROM with one-cycle read latency.
  always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

  assign pal_red   = pal_r(pal_index);
  assign pal_green = pal_g(pal_index);
  assign pal_blue  = pal_b(pal_index);
  assign bg_red    = bg_r(DrawX);
  assign bg_green  = bg_g(DrawY);
  assign bg_blue   = bg_b(DrawX, DrawY);

  task automatic model_edge(input logic [9:0] x, input logic [9:0] y);
    bit fs;
    fs = (x == 10'd0) && (y == 10'd0);
    if (reset) begin
      m_pend_x = 0; m_pend_y = 0; m_shad_x = 0; m_shad_y = 0;
      m_flag = 0; m_pend_mir = 0; m_shad_mir = 0; m_div = 0; m_frame = 0;
      m_init = 1;
    end else begin
      if (fs && m_flag) begin
        m_shad_x = m_pend_x; m_shad_y = m_pend_y; m_shad_mir = m_pend_mir;
      end
      if (pos_load) begin
        m_pend_x = int'(sprite_x); m_pend_y = int'(sprite_y); m_flag = 1;
`ifdef SPRITE_MIRROR_EN
        m_pend_mir = mirror_h;
`endif
      end else if (fs) begin
        m_flag = 0;
      end
      if (fs && anim_en) begin
        if (m_div == 7) begin
          m_div = 0;
          m_frame = (m_frame + 1) % 4;
        end else begin
          m_div = m_div + 1;
        end
      end
    end
  endtask

  // One pixel per call; entered and left at a falling edge. want >= 0 adds a
  // literal address check on top of the model.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic blk,
                      input int want, input string tag);
    exp_t  e, fe;
    string ft;
    int    dx, dy, tx, addr;
    bit    inb;
    logic [1:0] idx;
    if (exp_q.size() == 2) begin
      fe = exp_q.pop_front();
      ft = tag_q.pop_front();
      checks++;
      assert ({red, green, blue, sprite_hit} === fe) else begin
        errors++;
        $error("FAIL %s_out observed %h expected %h", ft, {red, green, blue, sprite_hit}, fe);
      end
    end
    DrawX = x; DrawY = y; blank = blk;
    dx  = int'(x) - m_shad_x;
    dy  = int'(y) - m_shad_y;
    inb = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
    tx  = dx / 2;
    if (m_shad_mir) tx = 15 - tx;
    addr = inb ? (m_frame * 256 + (dy / 2) * 16 + tx) : 0;
    #1;
    if (m_init) begin
      checks++;
      assert (rom_address === 10'(addr)) else begin
        errors++;
        $error("FAIL %s_addr observed %0d expected %0d", tag, rom_address, addr);
      end
    end
    if (want >= 0) begin
      checks++;
      assert (rom_address === 10'(want)) else begin
        errors++;
        $error("FAIL %s_addr_const observed %0d expected %0d", tag, rom_address, want);
      end
    end
    idx = rom_fn(10'(addr));
    if (reset || !blk)        e = '0;
    else if (inb && idx != 0) e = '{pal_r(idx), pal_g(idx), pal_b(idx), 1'b1};
    else                      e = '{bg_r(x), bg_g(y), bg_b(x, y), 1'b0};
    // A reset edge also zeroes the output of the pixel driven just before it.
    if (reset && exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    model_edge(x, y);
    @(posedge vga_clk);
    @(negedge vga_clk);
    pos_load = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({red, green, blue, sprite_hit} === 13'd0) else begin
      errors++;
      $error("FAIL %s observed %h expected 0", tag, {red, green, blue, sprite_hit});
    end
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
    sprite_x = '0; sprite_y = '0; pos_load = 1'b0; anim_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
    mirror_h = 1'b0;
`endif
    @(negedge vga_clk);

    // Reset state.
    step(10'd5, 10'd5, 1'b1, -1, "rst0");
    step(10'd6, 10'd5, 1'b1, -1, "rst1");
    check_zero("reset_out");
    reset = 1'b0;

    // Place the sprite at (100,50) and apply it at frame start.
    sprite_x = 10'd100; sprite_y = 10'd50; pos_load = 1'b1;
    step(10'd300, 10'd200, 1'b1, -1, "load1");
    step(10'd0,   10'd0,   1'b1, -1, "fs1");
    step(10'd100, 10'd50,  1'b1,  0, "topleft");
    step(10'd101, 10'd50,  1'b1,  0, "tl_x1");
    step(10'd103, 10'd50,  1'b1,  1, "tx1");
    step(10'd131, 10'd50,  1'b1, 15, "tx15");
    step(10'd132, 10'd50,  1'b1,  0, "right_edge");
    step(10'd99,  10'd50,  1'b1,  0, "left_out");
    step(10'd100, 10'd81,  1'b1, 240, "bottom_row");
    step(10'd100, 10'd82,  1'b1,  0, "below");
    step(10'd110, 10'd60,  1'b0, -1, "blanked");

    // Sprite at (5,5): borrow on the left, transparent texel inside.
    sprite_x = 10'd5; sprite_y = 10'd5; pos_load = 1'b1;
    step(10'd400, 10'd100, 1'b1, -1, "load2");
    step(10'd0,   10'd0,   1'b1, -1, "fs2");
    step(10'd3,   10'd5,   1'b1,  0, "borrow");
    step(10'd5,   10'd5,   1'b1,  0, "s5_tl");
    step(10'd11,  10'd5,   1'b1,  3, "transparent");

    // Mid-frame load waits for frame start; a load at frame start applies the old pending.
    sprite_x = 10'd200; sprite_y = 10'd0; pos_load = 1'b1;
    step(10'd50,  10'd50,  1'b1, -1, "load3");
    step(10'd5,   10'd5,   1'b1,  0, "still_old");
    step(10'd200, 10'd0,   1'b1,  0, "not_yet");
    sprite_x = 10'd300; sprite_y = 10'd100; pos_load = 1'b1;
    step(10'd0,   10'd0,   1'b1, -1, "fs_load");
    step(10'd202, 10'd0,   1'b1,  1, "applied_old");
    step(10'd302, 10'd100, 1'b1,  0, "new_pending");
    step(10'd0,   10'd0,   1'b1, -1, "fs3");
    step(10'd302, 10'd100, 1'b1,  1, "applied_new");

    // Animation: 8 enabled frame starts advance one frame; disabled ones hold.
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) step(10'd0, 10'd0, 1'b1, -1, "anim_a");
    anim_en = 1'b0;
    for (int i = 0; i < 5; i++) step(10'd0, 10'd0, 1'b1, -1, "anim_hold");
    step(10'd302, 10'd100, 1'b1, 257, "frame1");
    anim_en = 1'b1;
    for (int i = 0; i < 24; i++) step(10'd0, 10'd0, 1'b1, -1, "anim_b");
    anim_en = 1'b0;
    step(10'd302, 10'd100, 1'b1, 1, "frame_wrap");

`ifdef SPRITE_MIRROR_EN
    sprite_x = 10'd300; sprite_y = 10'd100; mirror_h = 1'b1; pos_load = 1'b1;
    step(10'd500, 10'd400, 1'b1, -1, "load_mir");
    mirror_h = 1'b0;
    step(10'd0,   10'd0,   1'b1, -1, "fs_mir");
    step(10'd300, 10'd100, 1'b1, 15, "mir_left");
    step(10'd331, 10'd100, 1'b1,  0, "mir_right");
`endif

    // Reset in the middle of a line.
    step(10'd310, 10'd100, 1'b1, -1, "pre_rst");
    reset = 1'b1;
    step(10'd312, 10'd100, 1'b1, -1, "mid_rst");
    check_zero("rst_mid_out");
    reset = 1'b0;
    step(10'd2, 10'd2, 1'b1, 17, "post_rst");
    step(10'd3, 10'd2, 1'b1, -1, "post_rst2");
    step(10'd0, 10'd5, 1'b0, -1, "drain0");
    step(10'd1, 10'd1, 1'b1, -1, "drain1");
    step(10'd1, 10'd1, 1'b1, -1, "drain2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
